// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Purpose  : Shared encodings for the RV32I decode stage: opcode, funct3 and
//             funct7 values, micro-op control codes, the micro-op record and
//             the skid-buffer state type.
//  Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

  // These widths must track the XLEN / ADDR_LEN parameters of decode_stage_hs.
  localparam int UOP_XLEN     = 32;
  localparam int UOP_ADDR_LEN = 32;

  // Major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // ALU funct3 values
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SR      = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  // funct7 values
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ALU operations
  localparam logic [3:0] ALU_OP_NOP  = 4'd0;
  localparam logic [3:0] ALU_OP_ADD  = 4'd1;
  localparam logic [3:0] ALU_OP_SUB  = 4'd2;
  localparam logic [3:0] ALU_OP_SLL  = 4'd3;
  localparam logic [3:0] ALU_OP_SLT  = 4'd4;
  localparam logic [3:0] ALU_OP_SLTU = 4'd5;
  localparam logic [3:0] ALU_OP_XOR  = 4'd6;
  localparam logic [3:0] ALU_OP_SRL  = 4'd7;
  localparam logic [3:0] ALU_OP_SRA  = 4'd8;
  localparam logic [3:0] ALU_OP_OR   = 4'd9;
  localparam logic [3:0] ALU_OP_AND  = 4'd10;

  // Operand selects
  localparam logic [1:0] OPSEL_RS1  = 2'd0;
  localparam logic [1:0] OPSEL_RS2  = 2'd0;
  localparam logic [1:0] OPSEL_PC   = 2'd1;
  localparam logic [1:0] OPSEL_IMM  = 2'd1;
  localparam logic [1:0] OPSEL_ZERO = 2'd2;

  // Writeback selects
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DMEM = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  typedef struct packed {
    logic [UOP_ADDR_LEN-1:0] pc;
    logic [3:0]              alu_func;
    logic [1:0]              opsel1;
    logic [1:0]              opsel2;
    logic [1:0]              wbsel;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [4:0]              rd_addr;
    logic                    rf_w_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic [2:0]              mem_size;
    logic                    is_branch;
    logic                    is_jump;
    logic [2:0]              br_type;
    logic [UOP_XLEN-1:0]     imm;
    logic                    illegal;
    logic                    is_muldiv;
    logic [2:0]              muldiv_op;
  } uop_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Base-encoding (funct7 = 0) ALU operation for an OP / OP-IMM funct3.
  function automatic logic [3:0] alu_op_base(input logic [2:0] f3);
    logic [3:0] r;
    r = ALU_OP_NOP;
    case (f3)
      FUNCT3_ADD_SUB: r = ALU_OP_ADD;
      FUNCT3_SLL:     r = ALU_OP_SLL;
      FUNCT3_SLT:     r = ALU_OP_SLT;
      FUNCT3_SLTU:    r = ALU_OP_SLTU;
      FUNCT3_XOR:     r = ALU_OP_XOR;
      FUNCT3_SR:      r = ALU_OP_SRL;
      FUNCT3_OR:      r = ALU_OP_OR;
      FUNCT3_AND:     r = ALU_OP_AND;
      default:        r = ALU_OP_NOP;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
// ============================================================================
//  Module   : decode_logic
//  Purpose  : Purely combinational RV32I instruction -> micro-op decoder.
//             Optional feature macro: DECODE_RV32M_EN (M-extension decode).
//  Revision : 1.0  initial release
// ============================================================================
module decode_logic
  import decode_pkg::*;
(
  input  logic [UOP_ADDR_LEN-1:0] i_pc,
  input  logic [31:0]             i_inst,
  output uop_t                    o_uop
);

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic [UOP_XLEN-1:0] w_imm_i;
  logic [UOP_XLEN-1:0] w_imm_s;
  logic [UOP_XLEN-1:0] w_imm_b;
  logic [UOP_XLEN-1:0] w_imm_u;
  logic [UOP_XLEN-1:0] w_imm_j;
  logic [UOP_XLEN-1:0] w_imm_sh;
  uop_t                w_dec;
  logic                w_bad;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];

  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u  = {i_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_sh = {27'b0, i_inst[24:20]};

  // Per-opcode control decode; w_bad flags any encoding we do not support.
  always_comb begin
    w_dec          = '0;
    w_bad          = 1'b0;
    w_dec.pc       = i_pc;
    w_dec.rs1_addr = i_inst[19:15];
    w_dec.rs2_addr = i_inst[24:20];
    w_dec.rd_addr  = i_inst[11:7];
    case (w_opcode)
      OP_LUI: begin
        w_dec.alu_func = ALU_OP_ADD;
        w_dec.opsel1   = OPSEL_ZERO;
        w_dec.opsel2   = OPSEL_IMM;
        w_dec.wbsel    = WB_IMM;
        w_dec.rf_w_en  = 1'b1;
        w_dec.imm      = w_imm_u;
      end
      OP_AUIPC: begin
        w_dec.alu_func = ALU_OP_ADD;
        w_dec.opsel1   = OPSEL_PC;
        w_dec.opsel2   = OPSEL_IMM;
        w_dec.wbsel    = WB_ALU;
        w_dec.rf_w_en  = 1'b1;
        w_dec.imm      = w_imm_u;
      end
      OP_JAL: begin
        w_dec.alu_func = ALU_OP_ADD;
        w_dec.opsel1   = OPSEL_PC;
        w_dec.opsel2   = OPSEL_IMM;
        w_dec.wbsel    = WB_PC;
        w_dec.rf_w_en  = 1'b1;
        w_dec.is_jump  = 1'b1;
        w_dec.imm      = w_imm_j;
      end
      OP_JALR: begin
        w_bad          = (w_funct3 != 3'b000);
        w_dec.alu_func = ALU_OP_ADD;
        w_dec.opsel1   = OPSEL_RS1;
        w_dec.opsel2   = OPSEL_IMM;
        w_dec.wbsel    = WB_PC;
        w_dec.rf_w_en  = 1'b1;
        w_dec.is_jump  = 1'b1;
        w_dec.imm      = w_imm_i;
      end
      OP_BRANCH: begin
        // Branch target is PC + imm; the comparison itself is chosen by br_type.
        w_bad           = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        w_dec.alu_func  = ALU_OP_ADD;
        w_dec.opsel1    = OPSEL_PC;
        w_dec.opsel2    = OPSEL_IMM;
        w_dec.is_branch = 1'b1;
        w_dec.br_type   = w_funct3;
        w_dec.imm       = w_imm_b;
      end
      OP_LOAD: begin
        w_bad          = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
        w_dec.alu_func = ALU_OP_ADD;
        w_dec.opsel1   = OPSEL_RS1;
        w_dec.opsel2   = OPSEL_IMM;
        w_dec.wbsel    = WB_DMEM;
        w_dec.rf_w_en  = 1'b1;
        w_dec.mem_r_en = 1'b1;
        w_dec.mem_size = w_funct3;
        w_dec.imm      = w_imm_i;
      end
      OP_STORE: begin
        w_bad          = (w_funct3[2] == 1'b1) || (w_funct3 == 3'b011);
        w_dec.alu_func = ALU_OP_ADD;
        w_dec.opsel1   = OPSEL_RS1;
        w_dec.opsel2   = OPSEL_IMM;
        w_dec.mem_w_en = 1'b1;
        w_dec.mem_size = w_funct3;
        w_dec.imm      = w_imm_s;
      end
      OP_IMM: begin
        w_dec.alu_func = alu_op_base(w_funct3);
        w_dec.opsel1   = OPSEL_RS1;
        w_dec.opsel2   = OPSEL_IMM;
        w_dec.wbsel    = WB_ALU;
        w_dec.rf_w_en  = 1'b1;
        w_dec.imm      = w_imm_i;
        if (w_funct3 == FUNCT3_SLL) begin
          w_bad     = (w_funct7 != FUNCT7_BASE);
          w_dec.imm = w_imm_sh;
        end else if (w_funct3 == FUNCT3_SR) begin
          w_bad     = (w_funct7 != FUNCT7_BASE) && (w_funct7 != FUNCT7_ALT);
          w_dec.imm = w_imm_sh;
          if (w_funct7 == FUNCT7_ALT) begin
            w_dec.alu_func = ALU_OP_SRA;
          end
        end
      end
      OP_OP: begin
        w_dec.opsel1  = OPSEL_RS1;
        w_dec.opsel2  = OPSEL_RS2;
        w_dec.wbsel   = WB_ALU;
        w_dec.rf_w_en = 1'b1;
        case (w_funct7)
          FUNCT7_BASE: w_dec.alu_func = alu_op_base(w_funct3);
          FUNCT7_ALT: begin
            if (w_funct3 == FUNCT3_ADD_SUB) begin
              w_dec.alu_func = ALU_OP_SUB;
            end else if (w_funct3 == FUNCT3_SR) begin
              w_dec.alu_func = ALU_OP_SRA;
            end else begin
              w_bad = 1'b1;
            end
          end
`ifdef DECODE_RV32M_EN
          FUNCT7_MULDIV: begin
            w_dec.alu_func  = ALU_OP_NOP;
            w_dec.is_muldiv = 1'b1;
            w_dec.muldiv_op = w_funct3;
          end
`endif
          default: w_bad = 1'b1;
        endcase
      end
      // FENCE is a no-op for an in-order core without caches.
      OP_FENCE: w_bad = (w_funct3 != 3'b000);
      // SYSTEM and everything else is left to EX to trap on.
      default:  w_bad = 1'b1;
    endcase
  end

  // Illegal encodings flow as an inert uop; x0 destinations never write.
  always_comb begin
    o_uop = w_dec;
    if (w_bad) begin
      o_uop          = '0;
      o_uop.pc       = i_pc;
      o_uop.rs1_addr = i_inst[19:15];
      o_uop.rs2_addr = i_inst[24:20];
      o_uop.rd_addr  = i_inst[11:7];
      o_uop.illegal  = 1'b1;
    end else if (w_dec.rd_addr == 5'd0) begin
      o_uop.rf_w_en = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_hs
//  Purpose  : ID stage: valid/ready handshake, 2-entry skid buffer and flush
//             around the combinational decode_logic.  in_ready comes only
//             from a register, so EX backpressure never reaches IF
//             combinationally.  Optional feature macro: DECODE_RV32M_EN.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage_hs
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_LEN-1:0] in_pc,
  input  logic [31:0]         in_inst,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_LEN-1:0] out_pc,
  output logic [3:0]          out_alu_func,
  output logic [1:0]          out_opsel1,
  output logic [1:0]          out_opsel2,
  output logic [1:0]          out_wbsel,
  output logic [4:0]          out_rs1_addr,
  output logic [4:0]          out_rs2_addr,
  output logic [4:0]          out_rd_addr,
  output logic                out_rf_w_en,
  output logic                out_mem_r_en,
  output logic                out_mem_w_en,
  output logic [2:0]          out_mem_size,
  output logic                out_is_branch,
  output logic                out_is_jump,
  output logic [2:0]          out_br_type,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_illegal,
  output logic                out_is_muldiv,
  output logic [2:0]          out_muldiv_op
);

  buf_state_e r_state;
  logic       r_full;
  logic       r_out_valid;
  uop_t       r_main;
  uop_t       r_skid;
  uop_t       w_uop;
  logic       w_in_ready;
  logic       w_push;
  logic       w_pop;

  decode_logic u_decode_logic (
    .i_pc   (in_pc),
    .i_inst (in_inst),
    .o_uop  (w_uop)
  );

  // r_full mirrors (state == TWO); the reset term holds in_ready low while
  // reset is asserted and lets it rise in the very first cycle afterwards.
  assign w_in_ready = ~r_full & ~reset;
  assign w_push     = in_valid & w_in_ready;
  assign w_pop      = r_out_valid & out_ready;

  // Skid-buffer state machine: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_main      <= w_uop;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_main <= w_uop;
          end else if (w_push) begin
            r_skid  <= w_uop;
            r_state <= ST_TWO;
            r_full  <= 1'b1;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_main  <= r_skid;
            r_state <= ST_ONE;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_full      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_out_valid;
  assign out_pc        = r_main.pc;
  assign out_alu_func  = r_main.alu_func;
  assign out_opsel1    = r_main.opsel1;
  assign out_opsel2    = r_main.opsel2;
  assign out_wbsel     = r_main.wbsel;
  assign out_rs1_addr  = r_main.rs1_addr;
  assign out_rs2_addr  = r_main.rs2_addr;
  assign out_rd_addr   = r_main.rd_addr;
  assign out_rf_w_en   = r_main.rf_w_en;
  assign out_mem_r_en  = r_main.mem_r_en;
  assign out_mem_w_en  = r_main.mem_w_en;
  assign out_mem_size  = r_main.mem_size;
  assign out_is_branch = r_main.is_branch;
  assign out_is_jump   = r_main.is_jump;
  assign out_br_type   = r_main.br_type;
  assign out_imm       = r_main.imm;
  assign out_illegal   = r_main.illegal;
  // decode_logic only sets these when DECODE_RV32M_EN is defined.
  assign out_is_muldiv = r_main.is_muldiv;
  assign out_muldiv_op = r_main.muldiv_op;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage_hs
//  Purpose  : Self-checking bench for decode_stage_hs: directed decode cases,
//             backpressure, flush and a randomized run against a queue-based
//             reference model.  Honours DECODE_RV32M_EN like the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage_hs;
  import decode_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic [1:0]  wb;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf;
    logic        mr;
    logic        mw;
    logic [2:0]  msize;
    logic        br;
    logic        jmp;
    logic [2:0]  brt;
    logic [31:0] imm;
    logic        ill;
    logic        md;
    logic [2:0]  mdop;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_alu_func;
  logic [1:0]  out_opsel1;
  logic [1:0]  out_opsel2;
  logic [1:0]  out_wbsel;
  logic [4:0]  out_rs1_addr;
  logic [4:0]  out_rs2_addr;
  logic [4:0]  out_rd_addr;
  logic        out_rf_w_en;
  logic        out_mem_r_en;
  logic        out_mem_w_en;
  logic [2:0]  out_mem_size;
  logic        out_is_branch;
  logic        out_is_jump;
  logic [2:0]  out_br_type;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic        out_is_muldiv;
  logic [2:0]  out_muldiv_op;

  int n_checks;
  int n_pass;
  logic [3:0] base_alu [0:7];
  exp_t obs;

  decode_stage_hs #(.XLEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_func(out_alu_func), .out_opsel1(out_opsel1), .out_opsel2(out_opsel2),
    .out_wbsel(out_wbsel), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rd_addr(out_rd_addr), .out_rf_w_en(out_rf_w_en), .out_mem_r_en(out_mem_r_en),
    .out_mem_w_en(out_mem_w_en), .out_mem_size(out_mem_size),
    .out_is_branch(out_is_branch), .out_is_jump(out_is_jump), .out_br_type(out_br_type),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .out_is_muldiv(out_is_muldiv), .out_muldiv_op(out_muldiv_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {out_pc, out_alu_func, out_opsel1, out_opsel2, out_wbsel,
                out_rs1_addr, out_rs2_addr, out_rd_addr, out_rf_w_en,
                out_mem_r_en, out_mem_w_en, out_mem_size, out_is_branch,
                out_is_jump, out_br_type, out_imm, out_illegal,
                out_is_muldiv, out_muldiv_op};

  // Reference decode built directly from the RV32I instruction tables.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    exp_t bad;
    logic ok;
    int t;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    e = '0;
    e.pc = pc; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
    ok = 1'b1;
    case (opc)
      7'b0110111: begin
        e.alu = ALU_OP_ADD; e.op1 = OPSEL_ZERO; e.op2 = OPSEL_IMM; e.wb = WB_IMM;
        e.rf = 1; e.imm = inst & 32'hFFFF_F000;
      end
      7'b0010111: begin
        e.alu = ALU_OP_ADD; e.op1 = OPSEL_PC; e.op2 = OPSEL_IMM; e.wb = WB_ALU;
        e.rf = 1; e.imm = inst & 32'hFFFF_F000;
      end
      7'b1101111: begin
        e.alu = ALU_OP_ADD; e.op1 = OPSEL_PC; e.op2 = OPSEL_IMM; e.wb = WB_PC;
        e.rf = 1; e.jmp = 1;
        t = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
        e.imm = t;
      end
      7'b1100111: begin
        ok = (f3 == 0);
        e.alu = ALU_OP_ADD; e.op1 = OPSEL_RS1; e.op2 = OPSEL_IMM; e.wb = WB_PC;
        e.rf = 1; e.jmp = 1;
        t = $signed(inst[31:20]); e.imm = t;
      end
      7'b1100011: begin
        ok = !(f3 == 2 || f3 == 3);
        e.alu = ALU_OP_ADD; e.op1 = OPSEL_PC; e.op2 = OPSEL_IMM;
        e.br = 1; e.brt = f3;
        t = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
        e.imm = t;
      end
      7'b0000011: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        e.alu = ALU_OP_ADD; e.op1 = OPSEL_RS1; e.op2 = OPSEL_IMM; e.wb = WB_DMEM;
        e.rf = 1; e.mr = 1; e.msize = f3;
        t = $signed(inst[31:20]); e.imm = t;
      end
      7'b0100011: begin
        ok = (f3 <= 2);
        e.alu = ALU_OP_ADD; e.op1 = OPSEL_RS1; e.op2 = OPSEL_IMM;
        e.mw = 1; e.msize = f3;
        t = $signed({inst[31:25], inst[11:7]}); e.imm = t;
      end
      7'b0010011: begin
        e.op1 = OPSEL_RS1; e.op2 = OPSEL_IMM; e.wb = WB_ALU; e.rf = 1;
        e.alu = base_alu[f3];
        t = $signed(inst[31:20]); e.imm = t;
        if (f3 == 1) begin
          ok = (f7 == 0); e.imm = {27'b0, inst[24:20]};
        end
        if (f3 == 5) begin
          ok = (f7 == 0 || f7 == 7'h20); e.imm = {27'b0, inst[24:20]};
          if (f7 == 7'h20) e.alu = ALU_OP_SRA;
        end
      end
      7'b0110011: begin
        e.op1 = OPSEL_RS1; e.op2 = OPSEL_RS2; e.wb = WB_ALU; e.rf = 1;
        if (f7 == 0) e.alu = base_alu[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_OP_SUB;
        else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_OP_SRA;
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'h01) begin
          e.alu = ALU_OP_NOP; e.md = 1; e.mdop = f3;
        end
`endif
        else ok = 1'b0;
      end
      7'b0001111: ok = (f3 == 0);
      default:    ok = 1'b0;
    endcase
    if (!ok) begin
      bad = '0;
      bad.pc = pc; bad.rs1 = inst[19:15]; bad.rs2 = inst[24:20]; bad.rd = inst[11:7];
      bad.ill = 1'b1;
      return bad;
    end
    if (e.rd == 0) e.rf = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0] ops [0:10];
    int k;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k <= 10) r[6:0] = ops[k];
    if (r[6:0] == 7'b0110011 || r[6:0] == 7'b0010011) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1; in_valid = 0; flush = 0; out_ready = 0; in_pc = 0; in_inst = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++;
    if (obs !== '0) $display("FAIL rst_outputs got=%h exp=0", obs); else n_pass++;
    reset = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_first_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_addi();
    in_valid = 1; in_pc = 32'h0000_0100; in_inst = 32'hFFF1_0093; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", out_valid); else n_pass++;
    n_checks++;
    if ({out_alu_func, out_opsel2, out_rd_addr, out_rf_w_en} !== {ALU_OP_ADD, OPSEL_IMM, 5'd1, 1'b1})
      $display("FAIL addi_ctrl got alu=%0d op2=%0d rd=%0d we=%b exp alu=%0d op2=%0d rd=1 we=1",
               out_alu_func, out_opsel2, out_rd_addr, out_rf_w_en, ALU_OP_ADD, OPSEL_IMM);
    else n_pass++;
    n_checks++;
    if (out_imm !== 32'hFFFF_FFFF) $display("FAIL addi_imm got=%h exp=ffffffff", out_imm); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL addi_drain got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_beq();
    in_valid = 1; in_pc = 32'h0000_0200; in_inst = 32'h0020_8463; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_checks++;
    if ({out_valid, out_is_branch, out_br_type, out_rf_w_en} !== {1'b1, 1'b1, 3'b000, 1'b0})
      $display("FAIL beq_ctrl got v=%b br=%b type=%0d we=%b exp v=1 br=1 type=0 we=0",
               out_valid, out_is_branch, out_br_type, out_rf_w_en);
    else n_pass++;
    n_checks++;
    if (out_imm !== 32'h0000_0008) $display("FAIL beq_imm got=%h exp=00000008", out_imm); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    in_valid = 1; in_pc = 32'h0000_0300; in_inst = 32'h0000_007F; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_checks++;
    if ({out_valid, out_illegal, out_rf_w_en, out_mem_w_en, out_mem_r_en, out_alu_func} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_NOP})
      $display("FAIL illegal_ctrl got v=%b ill=%b we=%b mw=%b mr=%b alu=%0d exp v=1 ill=1 we=0 mw=0 mr=0 alu=0",
               out_valid, out_illegal, out_rf_w_en, out_mem_w_en, out_mem_r_en, out_alu_func);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [6:0] exp_v;
    in_valid = 1; in_pc = 32'h0000_0400; in_inst = 32'h0220_81B3; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
`ifdef DECODE_RV32M_EN
    exp_v = {1'b0, 1'b1, 3'd0, 1'b1, 1'b1};
`else
    exp_v = {1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
`endif
    n_checks++;
    if ({out_illegal, out_is_muldiv, out_muldiv_op, out_rf_w_en, out_valid} !== exp_v)
      $display("FAIL mul_ctrl got ill/md/op/we/v=%b exp=%b",
               {out_illegal, out_is_muldiv, out_muldiv_op, out_rf_w_en, out_valid}, exp_v);
    else n_pass++;
    n_checks++;
    if (out_rd_addr !== 5'd3) $display("FAIL mul_rd got=%0d exp=3", out_rd_addr); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [0:2];
    logic [31:0] got [$];
    int idx;
    logic will_push;
    pcs = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
    idx = 0;
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1; in_pc = pcs[idx]; in_inst = 32'h0000_0013;
      will_push = in_ready;
      @(negedge clk);
      if (will_push) idx++;
    end
    n_checks++;
    if (idx !== 2) $display("FAIL b2b_accepted got=%0d exp=2", idx); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_full_ready got=%b exp=0", in_ready); else n_pass++;
    out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 3);
      in_pc = pcs[(idx < 3) ? idx : 0];
      will_push = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_pc);
      @(negedge clk);
      if (will_push) idx++;
    end
    in_valid = 0;
    n_checks++;
    if (got.size() !== 3) $display("FAIL b2b_count got=%0d exp=3", got.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== pcs[i]) $display("FAIL b2b_order[%0d] got=%h exp=%h", i, got[i], pcs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_pc = 32'h0000_2000; in_inst = 32'h0000_0013;
    @(negedge clk);
    in_pc = 32'h0000_2004;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_pre_full got=%b exp=0", in_ready); else n_pass++;
    flush = 1; in_pc = 32'h0000_2008;
    @(negedge clk);
    flush = 0; in_valid = 0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL flush_two got v/rdy=%b exp=01", {out_valid, in_ready}); else n_pass++;
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_stale[%0d] got=%b exp=0", c, out_valid); else n_pass++;
    end
    in_valid = 1; in_pc = 32'h0000_3000;
    @(negedge clk);
    flush = 1; in_pc = 32'h0000_3004;
    @(negedge clk);
    flush = 0; in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_one got=%b exp=0", out_valid); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_drop got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    exp_t q [$];
    logic fl, iv, orr, push, pop;
    logic [31:0] pc, inst;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++;
      if (out_valid !== (q.size() != 0))
        $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() != 0);
      else n_pass++;
      n_checks++;
      if (in_ready !== (q.size() < 2))
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2);
      else n_pass++;
      if (q.size() != 0) begin
        n_checks++;
        if (obs !== q[0]) $display("FAIL rnd_uop cyc=%0d got=%h exp=%h", cyc, obs, q[0]);
        else n_pass++;
      end
      fl   = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      orr  = ($urandom_range(0, 2) != 0);
      pc   = $urandom & 32'hFFFF_FFFC;
      inst = rand_inst();
      flush = fl; in_valid = iv; out_ready = orr; in_pc = pc; in_inst = inst;
      if (fl) begin
        q.delete();
      end else begin
        push = iv && (q.size() < 2);
        pop  = orr && (q.size() != 0);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(ref_decode(pc, inst));
      end
      @(negedge clk);
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    base_alu = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
                 ALU_OP_XOR, ALU_OP_SRL, ALU_OP_OR, ALU_OP_AND};
    test_reset();
    test_addi();
    test_beq();
    test_illegal();
    test_mul();
    test_back_to_back();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
